// File: rtl/calc_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the minimum-digit helper.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W = 4;

  // Smallest digit count whose decimal range exceeds every WIDTH-bit value.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned lim;
    longint unsigned p;
    int unsigned     d;
    lim = 64'd1 << width;
    p   = 64'd10;
    d   = 1;
    while (p <= lim) begin
      p = p * 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit correction for shift-and-add-3: digits of 5..9 get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] in_i,
  output logic [DIGIT_W-1:0] out_o
);

  // Digit values reaching this block are at most 9, so +3 never wraps.
  assign out_o = (in_i >= DIGIT_W'(5)) ? in_i + DIGIT_W'(3) : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock, with a
// start/busy/done handshake toward the display sequencer.
// Optional build macro: BCD_SIGNED_EN (two's-complement input, sign on neg).
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        neg
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Too few digits would silently truncate large operands.
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sh_q;
  logic [BCD_W-1:0]   dig_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;

  logic [BCD_W-1:0]   dig_corr;
  logic [BCD_W-1:0]   dig_d;
  logic [WIDTH-1:0]   sh_d;
  logic [WIDTH-1:0]   mag;
  logic               accept;
  logic               last_shift;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (dig_q[g*DIGIT_W +: DIGIT_W]),
      .out_o (dig_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One step of the {digits, operand} left shift.
  assign dig_d = {dig_corr[BCD_W-2:0], sh_q[WIDTH-1]};
  assign sh_d  = {sh_q[WIDTH-2:0], 1'b0};

  assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BCD_SIGNED_EN
  logic neg_pend_q;
  logic neg_q;

  // Convert the magnitude; the sign travels separately.
  assign mag = bin[WIDTH-1] ? WIDTH'(~bin + WIDTH'(1)) : bin;
  assign neg = neg_q;

  // Capture sign on accept, publish it together with the digits.
  always_ff @(posedge clock) begin
    if (reset) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      if (accept) neg_pend_q <= bin[WIDTH-1];
      if (last_shift) neg_q  <= neg_pend_q;
    end
  end
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif

  // Control FSM, bit counter, scratch registers and registered outputs.
  // bcd is loaded on the edge entering DONE so it is valid with the done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= SHIFT;
            sh_q    <= mag;
            dig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          dig_q <= dig_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_shift) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= dig_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
